// File: rtl/servo_cmd_input.sv
// Button/switch conditioning for the servo PWM controller: synchronises the raw inputs,
// debounces the push button and issues one active-low latch strobe per debounced press.
module servo_cmd_input #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] sw_raw,
  input  logic       key_n_raw,
  output logic [7:0] duty,
  output logic [1:0] channelselect,
  output logic       latchbtn,
  output logic       key_db,
  output logic [7:0] press_count
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // The state-entry edge already consumed one stable sample, so the wait ends one count early.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    STROBE,
    HELD,
    RELEASE_WAIT
  } state_t;

  logic [SYNC_STAGES-1:0]       key_sync_q, key_sync_d;
  logic [SYNC_STAGES-1:0][9:0]  sw_sync_q, sw_sync_d;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       duty_q, duty_d;
  logic [1:0]       chan_q, chan_d;
  logic             latch_q, latch_d;
  logic             key_db_q, key_db_d;
  logic [7:0]       press_q, press_d;

  logic             k;
  logic [9:0]       s;

  assign k = key_sync_q[SYNC_STAGES-1];
  assign s = sw_sync_q[SYNC_STAGES-1];

  always_comb begin
    key_sync_d = {key_sync_q[SYNC_STAGES-2:0], key_n_raw};
    sw_sync_d  = {sw_sync_q[SYNC_STAGES-2:0], sw_raw};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    duty_d   = duty_q;
    chan_d   = chan_q;
    latch_d  = 1'b1;
    key_db_d = key_db_q;
    press_d  = press_q;
    case (state_q)
      IDLE: begin
        if (!k) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (k) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Capture a cycle ahead of the strobe so the controller sees settled data.
          state_d = STROBE;
          cnt_d   = '0;
          duty_d  = s[7:0];
          chan_d  = s[9:8];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STROBE: begin
        state_d  = HELD;
        cnt_d    = '0;
        latch_d  = 1'b0;
        key_db_d = 1'b1;
        press_d  = press_q + 8'd1;
      end
      HELD: begin
        if (k) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!k) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = IDLE;
          cnt_d    = '0;
          key_db_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Key synchroniser resets to "released" so a reset never looks like a press edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_sync_q <= '1;
      sw_sync_q  <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      duty_q     <= 8'h00;
      chan_q     <= 2'd0;
      latch_q    <= 1'b1;
      key_db_q   <= 1'b0;
      press_q    <= 8'h00;
    end else begin
      key_sync_q <= key_sync_d;
      sw_sync_q  <= sw_sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      chan_q     <= chan_d;
      latch_q    <= latch_d;
      key_db_q   <= key_db_d;
      press_q    <= press_d;
    end
  end

  assign duty          = duty_q;
  assign channelselect = chan_q;
  assign latchbtn      = latch_q;
  assign key_db        = key_db_q;
  assign press_count   = press_q;

endmodule

// File: tb/tb_servo_cmd_input.sv
// Scoreboard bench for servo_cmd_input: a run-length debounce model predicts each strobe
// and the steady output values; a negedge monitor compares them against the DUT.
module tb_servo_cmd_input;

  localparam int DEB = 16;
  localparam int SYN = 2;

  logic       clock;
  logic       reset;
  logic [9:0] sw_raw;
  logic       key_n_raw;
  logic [7:0] duty;
  logic [1:0] channelselect;
  logic       latchbtn;
  logic       key_db;
  logic [7:0] press_count;

  int checks   = 0;
  int errors   = 0;
  int nstrobes = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] d;
    logic [1:0] c;
    logic [7:0] n;
    int         t;
  } strobe_t;

  strobe_t sb[$];

  logic [7:0] exp_duty;
  logic [1:0] exp_chan;
  logic       exp_keydb;
  logic [7:0] exp_count;

  servo_cmd_input #(
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SYN)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .sw_raw       (sw_raw),
    .key_n_raw    (key_n_raw),
    .duty         (duty),
    .channelselect(channelselect),
    .latchbtn     (latchbtn),
    .key_db       (key_db),
    .press_count  (press_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Reference model: the FSM sees raw samples SYN edges late; a level change is accepted
  // after DEB consecutive samples of the new level, and the strobe edge ignores the key.
  initial begin
    logic [10:0] hist[$];
    logic [10:0] seen;
    int          run;
    bit          pressed;
    bit          block;
    run = 0; pressed = 0; block = 0;
    exp_duty = 8'h00; exp_chan = 2'd0; exp_keydb = 1'b0; exp_count = 8'h00;
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        hist.delete();
        repeat (SYN) hist.push_back({1'b1, 10'h000});
        run = 0; pressed = 0; block = 0;
        exp_duty = 8'h00; exp_chan = 2'd0; exp_keydb = 1'b0; exp_count = 8'h00;
        sb.delete();
      end else begin
        cyc++;
        seen = hist.pop_front();
        hist.push_back({key_n_raw, sw_raw});
        if (block) begin
          block = 0;
          run = 0;
          exp_count = exp_count + 8'd1;
          exp_keydb = 1'b1;
        end else if (!pressed) begin
          run = seen[10] ? 0 : run + 1;
          if (run == DEB) begin
            exp_duty = seen[7:0];
            exp_chan = seen[9:8];
            sb.push_back('{exp_duty, exp_chan, exp_count + 8'd1, cyc + 1});
            pressed = 1; block = 1; run = 0;
          end
        end else begin
          run = seen[10] ? run + 1 : 0;
          if (run == DEB) begin
            pressed = 0; run = 0;
            exp_keydb = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    strobe_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (latchbtn === 1'b0) begin
          nstrobes++;
          if (sb.size() == 0) begin
            chk("latch_unexpected", {31'd0, latchbtn}, 32'd1);
          end else begin
            e = sb.pop_front();
            chk("strobe_cycle", cyc, e.t);
            chk("strobe_duty", {24'd0, duty}, {24'd0, e.d});
            chk("strobe_chan", {30'd0, channelselect}, {30'd0, e.c});
            chk("strobe_count", {24'd0, press_count}, {24'd0, e.n});
          end
        end else if (sb.size() > 0 && sb[0].t < cyc) begin
          chk("latch_missed", {31'd0, latchbtn}, 32'd0);
          void'(sb.pop_front());
        end
        chk("steady_outputs", {13'd0, duty, channelselect, key_db, press_count},
            {13'd0, exp_duty, exp_chan, exp_keydb, exp_count});
      end
    end
  end

  initial begin
    logic [9:0] first_sw;
    logic [7:0] cnt0;
    int         len;

    reset = 1'b1; key_n_raw = 1'b1; sw_raw = 10'h3FF;
    repeat (5) begin
      @(negedge clock);
      chk("reset_outputs", {12'd0, duty, channelselect, latchbtn, key_db, press_count},
          {12'd0, 8'h00, 2'd0, 1'b1, 1'b0, 8'h00});
    end
    reset = 1'b0;
    step(100);
    chk("idle_after_100", {12'd0, duty, channelselect, latchbtn, key_db, press_count},
        {12'd0, 8'h00, 2'd0, 1'b1, 1'b0, 8'h00});

    // Single clean press with directed latency checks.
    sw_raw = 10'h1FF; key_n_raw = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (i == 17) chk("duty_before_capture", {24'd0, duty}, 32'h00);
      if (i == 18) begin
        chk("duty_at_capture", {24'd0, duty}, 32'hFF);
        chk("chan_at_capture", {30'd0, channelselect}, 32'd1);
        chk("latch_high_at_capture", {31'd0, latchbtn}, 32'd1);
      end
      if (i == 19) begin
        chk("latch_low_cycle19", {31'd0, latchbtn}, 32'd0);
        chk("count_after_press", {24'd0, press_count}, 32'd1);
        chk("key_db_set", {31'd0, key_db}, 32'd1);
      end
      if (i == 20) chk("latch_one_cycle", {31'd0, latchbtn}, 32'd1);
    end
    key_n_raw = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clock);
      if (j == 17) chk("key_db_still_held", {31'd0, key_db}, 32'd1);
      if (j == 18) chk("key_db_released", {31'd0, key_db}, 32'd0);
    end

    // Bounce: two short low runs must not strobe.
    key_n_raw = 1'b0; step(10);
    key_n_raw = 1'b1; step(3);
    key_n_raw = 1'b0; step(10);
    key_n_raw = 1'b1; step(40);
    chk("bounce_count", {24'd0, press_count}, 32'd1);
    chk("bounce_strobes", nstrobes, 32'd1);
    chk("bounce_duty", {22'd0, channelselect, duty}, {22'd0, 2'd1, 8'hFF});

    // Long hold with a high glitch and moving switches.
    first_sw = 10'($urandom);
    for (int i = 0; i < 1000; i++) begin
      if (i == 0) sw_raw = first_sw;
      else if (i % 50 == 0) sw_raw = 10'($urandom);
      key_n_raw = (i >= 500 && i < 505) ? 1'b1 : 1'b0;
      step(1);
    end
    key_n_raw = 1'b1; step(40);
    chk("hold_strobes", nstrobes, 32'd2);
    chk("hold_count", {24'd0, press_count}, 32'd2);
    chk("hold_capture", {22'd0, channelselect, duty}, {22'd0, first_sw});

    // Four presses cycling the channel bits.
    for (int p = 0; p < 4; p++) begin
      sw_raw = {2'(p), 8'hFF};
      key_n_raw = 1'b0; step(25);
      chk("seq_chan", {30'd0, channelselect}, p);
      chk("seq_duty", {24'd0, duty}, 32'hFF);
      key_n_raw = 1'b1; step(40);
    end
    chk("seq_strobes", nstrobes, 32'd6);
    chk("seq_count", {24'd0, press_count}, 32'd6);

    // 256 clean presses: the counter must come back to where it started.
    cnt0 = press_count;
    for (int p = 0; p < 256; p++) begin
      sw_raw = 10'($urandom);
      key_n_raw = 1'b0; step(20);
      key_n_raw = 1'b1; step(20);
    end
    chk("count_wrap", {24'd0, press_count}, {24'd0, cnt0});
    chk("wrap_strobes", nstrobes, 32'd262);

    // Random press/release lengths straddling the debounce window.
    for (int p = 0; p < 150; p++) begin
      key_n_raw = 1'b0;
      len = $urandom_range(6, 30);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 3) == 0) sw_raw = 10'($urandom);
        step(1);
      end
      key_n_raw = 1'b1;
      len = $urandom_range(6, 30);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 3) == 0) sw_raw = 10'($urandom);
        step(1);
      end
    end
    step(40);

    // Asynchronous reset in the middle of the press debounce, key kept low.
    key_n_raw = 1'b0;
    step(13);
    #2 reset = 1'b1;
    #1 chk("async_reset_outputs", {12'd0, duty, channelselect, latchbtn, key_db, press_count},
           {12'd0, 8'h00, 2'd0, 1'b1, 1'b0, 8'h00});
    repeat (3) begin
      @(negedge clock);
      chk("latch_in_reset", {31'd0, latchbtn}, 32'd1);
    end
    reset = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clock);
      chk("post_reset_latch", {31'd0, latchbtn}, (i == 19) ? 32'd0 : 32'd1);
    end
    chk("post_reset_count", {24'd0, press_count}, 32'd1);
    key_n_raw = 1'b1; step(40);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
